mem_port_arbiter: RTL and testbench

- Shares one single-ported memory between the instruction-fetch requester (i_*) and the load/store requester (d_*). Used when the CPU moves from split instruction/data memories to a unified memory.
- Sits between the fetch/memory stages and the memory model.
- Allows one outstanding transaction at a time.
- Data requests have priority, with an anti-starvation limit for fetch and a watchdog timeout on the memory side.

---
 rtl/mem_port_arbiter_pkg.sv | 45 ++++
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter_watchdog.sv | 22 ++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam logic [31:0] RSP_ERR_DATA        = 32'h0;
  localparam int          DEF_TIMEOUT_CYCLES  = 64;
  localparam int          DEF_MAX_DATA_STREAK = 4;

  // Every output of the arbiter lives in one registered bundle.
  typedef struct packed {
    logic        i_gnt;
    logic        i_rvalid;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
  } arb_out_t;

  // Pulse the owner's rvalid with the given data/error.
  function automatic arb_out_t respond(arb_out_t o, owner_e own, logic [31:0] data, logic err);
    arb_out_t r;
    r           = o;
    r.i_rvalid  = (own == OWN_I);
    r.d_rvalid  = (own == OWN_D);
    r.rsp_rdata = data;
    r.rsp_err   = err;
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester + memory side bundle; slave = the arbiter, master = environment.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ready;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_ready, m_rvalid, m_rdata,
    output i_gnt, i_rvalid, d_gnt, d_rvalid, rsp_rdata, rsp_err,
           m_req, m_we, m_addr, m_wdata, m_wstrb
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_ready, m_rvalid, m_rdata,
    input  i_gnt, i_rvalid, d_gnt, d_rvalid, rsp_rdata, rsp_err,
           m_req, m_we, m_addr, m_wdata, m_wstrb
  );
endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Per-phase watchdog: clear on phase entry, count while enabled, flag last cycle.
module arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES);

  logic [W-1:0] cnt_q;

  // Clear wins over count; counter never passes TIMEOUT_CYCLES-1 because the FSM leaves.
  always_ff @(posedge clk or posedge rst)
    if (rst)      cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en)  cnt_q <= cnt_q + W'(1);

  assign expired = (cnt_q == W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter in front of a single-ported memory, one transaction in flight.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int            SW         = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  arb_state_e    state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [SW-1:0] streak_q, streak_d;
  arb_out_t      out_q, out_d;
  logic          wd_clr, wd_expired;
  logic          i_wait_q, d_wait_q;

  arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (state_q != ST_IDLE),
    .expired (wd_expired)
  );

  // Next state, arbitration and next registered outputs.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    streak_d       = streak_q;
    out_d          = out_q;
    out_d.i_gnt    = 1'b0;
    out_d.d_gnt    = 1'b0;
    out_d.i_rvalid = 1'b0;
    out_d.d_rvalid = 1'b0;
    wd_clr         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.d_req && !(bus.i_req && streak_q == STREAK_MAX)) begin
          owner_d       = OWN_D;
          out_d.d_gnt   = 1'b1;
          out_d.m_req   = 1'b1;
          out_d.m_we    = bus.d_we;
          out_d.m_addr  = bus.d_addr;
          out_d.m_wdata = bus.d_wdata;
          out_d.m_wstrb = bus.d_we ? bus.d_wstrb : 4'h0;
          // Data can only win against a pending fetch below the cap, so +1 never overflows.
          streak_d      = bus.i_req ? streak_q + SW'(1) : '0;
          wd_clr        = 1'b1;
          state_d       = ST_REQ;
        end else if (bus.i_req) begin
          owner_d       = OWN_I;
          out_d.i_gnt   = 1'b1;
          out_d.m_req   = 1'b1;
          out_d.m_we    = 1'b0;
          out_d.m_addr  = bus.i_addr;
          out_d.m_wdata = 32'h0;
          out_d.m_wstrb = 4'h0;
          streak_d      = '0;
          wd_clr        = 1'b1;
          state_d       = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.m_ready) begin
          out_d.m_req = 1'b0;
          if (out_q.m_we) begin
            out_d   = respond(out_d, owner_q, 32'h0, 1'b0);
            state_d = ST_IDLE;
          end else begin
            wd_clr  = 1'b1;
            state_d = ST_RESP;
          end
        end else if (wd_expired) begin
          out_d.m_req = 1'b0;
          out_d       = respond(out_d, owner_q, RSP_ERR_DATA, 1'b1);
          state_d     = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (bus.m_rvalid) begin
          out_d   = respond(out_d, owner_q, bus.m_rdata, 1'b0);
          state_d = ST_IDLE;
        end else if (wd_expired) begin
          out_d   = respond(out_d, owner_q, RSP_ERR_DATA, 1'b1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight transaction silently.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_I;
      streak_q <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      out_q    <= out_d;
    end

  assign bus.i_gnt     = out_q.i_gnt;
  assign bus.i_rvalid  = out_q.i_rvalid;
  assign bus.d_gnt     = out_q.d_gnt;
  assign bus.d_rvalid  = out_q.d_rvalid;
  assign bus.rsp_rdata = out_q.rsp_rdata;
  assign bus.rsp_err   = out_q.rsp_err;
  assign bus.m_req     = out_q.m_req;
  assign bus.m_we      = out_q.m_we;
  assign bus.m_addr    = out_q.m_addr;
  assign bus.m_wdata   = out_q.m_wdata;
  assign bus.m_wstrb   = out_q.m_wstrb;

  // Tracks requests that are pending and not yet granted; such a request must stay up.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      i_wait_q <= 1'b0;
      d_wait_q <= 1'b0;
    end else begin
      i_wait_q <= bus.i_req && !out_d.i_gnt && !out_q.i_gnt;
      d_wait_q <= bus.d_req && !out_d.d_gnt && !out_q.d_gnt;
    end

  a_i_hold: assert property (@(posedge clk) disable iff (rst) i_wait_q |-> bus.i_req);
  a_d_hold: assert property (@(posedge clk) disable iff (rst) d_wait_q |-> bus.d_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a response scoreboard.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.TIMEOUT_CYCLES(64), .MAX_DATA_STREAK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  wire [106:0] all_outs = {bus.i_gnt, bus.i_rvalid, bus.d_gnt, bus.d_rvalid, bus.rsp_rdata,
                           bus.rsp_err, bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_wstrb};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic is_d, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.is_d = is_d; e.rdata = rdata; e.err = err;
    q.push_back(e);
  endtask

  // Called in the first REQ cycle of a read; returns in the rvalid cycle.
  task automatic serve_read(input logic [31:0] data);
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready  = 1'b0;
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = data;
    tick();
    bus.m_rvalid = 1'b0;
  endtask

  // Scoreboard: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (bus.i_rvalid || bus.d_rvalid)) begin
      chk("rv_expected", (q.size() != 0), 1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        chk("rv_owner", {bus.d_rvalid, bus.i_rvalid}, mon_e.is_d ? 2'b10 : 2'b01);
        chk("rv_rdata", bus.rsp_rdata, mon_e.rdata);
        chk("rv_err", bus.rsp_err, mon_e.err);
      end
    end
  end

  initial begin
    int cnt;
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
    bus.d_wdata = 0; bus.d_wstrb = 0; bus.m_ready = 0; bus.m_rvalid = 0; bus.m_rdata = 0;

    // Reset state
    repeat (2) tick();
    chk("reset_outs", all_outs, 0);
    rst = 1'b0;
    tick();

    // Fetch read only
    bus.i_req = 1; bus.i_addr = 32'h100;
    push(0, 32'h00500093, 0);
    tick();
    chk("f_i_gnt", bus.i_gnt, 1);
    chk("f_d_gnt", bus.d_gnt, 0);
    chk("f_m_req", bus.m_req, 1);
    chk("f_m_addr", bus.m_addr, 32'h100);
    chk("f_m_we", bus.m_we, 0);
    bus.i_req = 0;
    serve_read(32'h00500093);
    chk("f_i_rvalid", bus.i_rvalid, 1);
    chk("f_rdata", bus.rsp_rdata, 32'h00500093);
    tick();
    chk("f_rvalid_pulse", bus.i_rvalid, 0);
    chk("f_rdata_hold", bus.rsp_rdata, 32'h00500093);

    // Simultaneous fetch and store: store first, fetch next
    bus.i_req = 1; bus.i_addr = 32'h300;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'hCAFEF00D; bus.d_wstrb = 4'hF;
    push(1, 32'h0, 0);
    push(0, 32'h11111111, 0);
    tick();
    chk("s_d_gnt", bus.d_gnt, 1);
    chk("s_i_gnt", bus.i_gnt, 0);
    chk("s_m_we", bus.m_we, 1);
    chk("s_m_addr", bus.m_addr, 32'h200);
    chk("s_m_wdata", bus.m_wdata, 32'hCAFEF00D);
    chk("s_m_wstrb", bus.m_wstrb, 4'hF);
    bus.d_req = 0; bus.d_we = 0;
    bus.m_ready = 1;
    tick();
    bus.m_ready = 0;
    chk("s_d_rvalid", bus.d_rvalid, 1);
    chk("s_m_req_drop", bus.m_req, 0);
    tick();
    chk("s_i_gnt_next", bus.i_gnt, 1);
    chk("s_i_addr", bus.m_addr, 32'h300);
    chk("s_m_wstrb_rd", bus.m_wstrb, 0);
    bus.i_req = 0;
    serve_read(32'h11111111);

    // Starvation: four data grants, then fetch is forced
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h400;
    bus.i_req = 1; bus.i_addr = 32'h500;
    for (int k = 0; k < 4; k++) begin
      push(1, 32'hD0 + k, 0);
      tick();
      chk("st_d_gnt", bus.d_gnt, 1);
      chk("st_i_wait", bus.i_gnt, 0);
      serve_read(32'hD0 + k);
    end
    push(0, 32'h1F, 0);
    tick();
    chk("st_i_forced", bus.i_gnt, 1);
    chk("st_d_held", bus.d_gnt, 0);
    chk("st_i_addr", bus.m_addr, 32'h500);
    bus.i_req = 0;
    serve_read(32'h1F);
    // Streak cleared: data wins again against a fresh fetch request
    bus.i_req = 1; bus.i_addr = 32'h504;
    push(1, 32'hE0, 0);
    tick();
    chk("st_cleared", bus.d_gnt, 1);
    bus.d_req = 0;
    serve_read(32'hE0);
    push(0, 32'h2F, 0);
    tick();
    chk("st_i_after", bus.i_gnt, 1);
    bus.i_req = 0;
    serve_read(32'h2F);

    // Timeout in REQ
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h600;
    push(1, 32'h0, 1);
    tick();
    chk("to_d_gnt", bus.d_gnt, 1);
    bus.d_req = 0;
    cnt = 0;
    for (int k = 0; k < 200 && bus.m_req; k++) begin
      cnt++;
      tick();
    end
    chk("to_m_req_cycles", cnt, 64);
    chk("to_d_rvalid", bus.d_rvalid, 1);
    chk("to_err", bus.rsp_err, 1);
    chk("to_rdata", bus.rsp_rdata, 32'h0);
    bus.i_req = 1; bus.i_addr = 32'h700;
    push(0, 32'h77, 0);
    tick();
    chk("to_next_gnt", bus.i_gnt, 1);
    bus.i_req = 0;
    serve_read(32'h77);

    // Race: m_rvalid in the final RESP timer cycle wins
    bus.d_req = 1; bus.d_addr = 32'h620;
    push(1, 32'hABCD1234, 0);
    tick();
    chk("rr_d_gnt", bus.d_gnt, 1);
    bus.d_req = 0;
    bus.m_ready = 1;
    tick();
    bus.m_ready = 0;
    repeat (63) tick();
    chk("rr_no_early_rv", bus.d_rvalid, 0);
    bus.m_rvalid = 1; bus.m_rdata = 32'hABCD1234;
    tick();
    bus.m_rvalid = 0;
    chk("rr_rvalid", bus.d_rvalid, 1);
    chk("rr_err", bus.rsp_err, 0);

    // Race: m_ready in the final REQ timer cycle wins
    bus.d_req = 1; bus.d_addr = 32'h640;
    push(1, 32'h55, 0);
    tick();
    bus.d_req = 0;
    repeat (63) tick();
    chk("rq_m_req_last", bus.m_req, 1);
    bus.m_ready = 1;
    tick();
    bus.m_ready = 0;
    chk("rq_no_err_rv", bus.d_rvalid, 0);
    chk("rq_m_req_drop", bus.m_req, 0);
    bus.m_rvalid = 1; bus.m_rdata = 32'h55;
    tick();
    bus.m_rvalid = 0;
    chk("rq_rvalid", bus.d_rvalid, 1);

    // Reset mid-operation while in RESP
    bus.i_req = 1; bus.i_addr = 32'h800;
    tick();
    chk("rs_i_gnt", bus.i_gnt, 1);
    bus.i_req = 0;
    bus.m_ready = 1;
    tick();
    bus.m_ready = 0;
    #2 rst = 1'b1;
    #1 chk("rs_async_outs", all_outs, 0);
    tick();
    tick();
    rst = 1'b0;
    bus.m_rvalid = 1; bus.m_rdata = 32'h99;
    tick();
    bus.m_rvalid = 0;
    chk("rs_late_rv", {bus.i_rvalid, bus.d_rvalid}, 0);
    tick();
    chk("rs_late_rv2", {bus.i_rvalid, bus.d_rvalid}, 0);
    chk("rs_m_req", bus.m_req, 0);

    tick();
    chk("sb_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
